// File: rtl/xb_gpio_pkg.sv
// Shared types and helpers for the expansion-board GPIO read-modify-write arbiter.
package xb_gpio_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_REG_ADDR = 0;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        ACK
    } state_t;

    function automatic logic [DEF_DATA_W-1:0] merge(
        input logic [DEF_DATA_W-1:0] old,
        input logic [DEF_DATA_W-1:0] mask,
        input logic [DEF_DATA_W-1:0] value
    );
        return (old & ~mask) | (value & mask);
    endfunction

endpackage

// File: rtl/xb_gpio_rmw_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    int   cand;
    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (en && !found && req[IDX_W'(cand)]) begin
                gnt[IDX_W'(cand)] = 1'b1;
                gnt_idx           = IDX_W'(cand);
                found             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xb_gpio_rmw_arbiter.sv
// Serialises atomic masked read-modify-write requests from several masters onto
// one zero-wait-state Avalon-MM GPIO register; all slave-facing outputs are registered.
module xb_gpio_rmw_arbiter
    import xb_gpio_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = 2,
    parameter int REG_ADDR = DEF_REG_ADDR
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_mask,
    input  logic [NUM_REQ*DATA_W-1:0]   req_value,
    output logic [NUM_REQ-1:0]          req_ack,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        busy,
    output logic [ADDR_W-1:0]           av_address,
    output logic                        av_chipselect,
    output logic                        av_write_n,
    output logic [DATA_W-1:0]           av_writedata,
    input  logic [DATA_W-1:0]           av_readdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t               state, state_next;
    logic [IDX_W-1:0]     ptr, ptr_next;
    logic [IDX_W-1:0]     gnt_idx, gnt_idx_q;
    logic [NUM_REQ-1:0]   gnt, gnt_q;
    logic                 arb_en;
    logic [DATA_W-1:0]    mask_q, value_q, old_q;
    logic [DATA_W-1:0]    merged_rd, merged_old;
    logic                 cs_next, write_n_next, busy_next;
    logic [DATA_W-1:0]    wdata_next, rsp_next;
    logic [NUM_REQ-1:0]   ack_next;

    assign av_address = ADDR_W'(REG_ADDR);
    assign arb_en     = (state == IDLE);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (ptr),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // READ merges the live slave data so the write strobe lands the very next cycle.
    assign merged_rd  = DATA_W'(merge(DEF_DATA_W'(av_readdata), DEF_DATA_W'(mask_q),
                                      DEF_DATA_W'(value_q)));
    assign merged_old = DATA_W'(merge(DEF_DATA_W'(old_q), DEF_DATA_W'(mask_q),
                                      DEF_DATA_W'(value_q)));

    always_comb begin
        state_next   = state;
        ptr_next     = ptr;
        cs_next      = 1'b0;
        write_n_next = 1'b1;
        wdata_next   = av_writedata;
        rsp_next     = rsp_data;
        ack_next     = '0;
        busy_next    = busy;
        case (state)
            IDLE: begin
                if (|gnt) begin
                    state_next = READ;
                    cs_next    = 1'b1;
                    busy_next  = 1'b1;
                end
            end
            READ: begin
                if (mask_q == '0) begin
                    state_next = ACK;
                    ack_next   = gnt_q;
                    rsp_next   = merged_rd;
                end else begin
                    state_next   = WRITE;
                    cs_next      = 1'b1;
                    write_n_next = 1'b0;
                    wdata_next   = merged_rd;
                end
            end
            WRITE: begin
                state_next = ACK;
                ack_next   = gnt_q;
                rsp_next   = merged_old;
            end
            ACK: begin
                state_next = IDLE;
                busy_next  = 1'b0;
                ptr_next   = (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            ptr           <= '0;
            gnt_q         <= '0;
            gnt_idx_q     <= '0;
            busy          <= 1'b0;
            req_ack       <= '0;
            rsp_data      <= '0;
            av_chipselect <= 1'b0;
            av_write_n    <= 1'b1;
            av_writedata  <= '0;
        end else begin
            state         <= state_next;
            ptr           <= ptr_next;
            busy          <= busy_next;
            req_ack       <= ack_next;
            rsp_data      <= rsp_next;
            av_chipselect <= cs_next;
            av_write_n    <= write_n_next;
            av_writedata  <= wdata_next;
            if (state == IDLE && |gnt) begin
                gnt_q     <= gnt;
                gnt_idx_q <= gnt_idx;
            end
        end
    end

    // Working data registers need no reset: they are always loaded before use.
    always_ff @(posedge clk) begin
        if (state == IDLE && |gnt) begin
            mask_q  <= req_mask[gnt_idx*DATA_W +: DATA_W];
            value_q <= req_value[gnt_idx*DATA_W +: DATA_W];
        end
        if (state == READ) begin
            old_q <= av_readdata;
        end
    end

endmodule

// File: tb/tb_xb_gpio_rmw_arbiter.sv
// Bench for xb_gpio_rmw_arbiter: GPIO register slave as load, timeline model plus directed literal checks.
module tb_xb_gpio_rmw_arbiter;

    localparam int NUM_REQ = 2;
    localparam int DW      = 32;
    localparam int MAXC    = 1024;

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic [NUM_REQ-1:0]      req_valid = '0;
    logic [NUM_REQ*DW-1:0]   req_mask = '0;
    logic [NUM_REQ*DW-1:0]   req_value = '0;
    logic [NUM_REQ-1:0]      req_ack;
    logic [DW-1:0]           rsp_data;
    logic                    busy;
    logic [1:0]              av_address;
    logic                    av_chipselect;
    logic                    av_write_n;
    logic [DW-1:0]           av_writedata;
    logic [DW-1:0]           av_readdata;

    xb_gpio_rmw_arbiter dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_mask      (req_mask),
        .req_value     (req_value),
        .req_ack       (req_ack),
        .rsp_data      (rsp_data),
        .busy          (busy),
        .av_address    (av_address),
        .av_chipselect (av_chipselect),
        .av_write_n    (av_write_n),
        .av_writedata  (av_writedata),
        .av_readdata   (av_readdata)
    );

    always #5 clk = ~clk;

    // GPIO register slave sharing reset_n with the arbiter.
    logic [DW-1:0] gpio_reg;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) gpio_reg <= '0;
        else if (av_chipselect && !av_write_n && av_address == 2'd0) gpio_reg <= av_writedata;
    end
    assign av_readdata = (av_chipselect && av_address == 2'd0) ? gpio_reg : '0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected-output timeline, indexed by cycle number.
    int                 cyc = 0;
    logic               e_cs      [0:MAXC-1];
    logic               e_wr      [0:MAXC-1];
    logic [DW-1:0]      e_wd      [0:MAXC-1];
    logic [NUM_REQ-1:0] e_ack     [0:MAXC-1];
    logic               e_busy    [0:MAXC-1];
    logic               e_rsp_set [0:MAXC-1];
    logic [DW-1:0]      e_rsp     [0:MAXC-1];
    int                 m_ptr = 0;
    int                 free_at = 0;
    logic [DW-1:0]      m_reg = '0;
    logic [DW-1:0]      held_rsp = '0;

    task automatic clear_cycle(input int c);
        if (c < MAXC) begin
            e_cs[c] = 1'b0; e_wr[c] = 1'b0; e_wd[c] = '0; e_ack[c] = '0;
            e_busy[c] = 1'b0; e_rsp_set[c] = 1'b0; e_rsp[c] = '0;
        end
    endtask

    // Model: when the arbiter is free and someone asks, pick the winner and lay out its op.
    always @(posedge clk) begin : model
        int w, a, idx;
        logic [DW-1:0] mk, vl, nv;
        if (!reset_n) begin
            for (int k = 0; k < 6; k++) clear_cycle(cyc + k);
            m_ptr   = 0;
            m_reg   = '0;
            free_at = cyc + 1;
        end else if (cyc >= free_at && |req_valid && cyc + 4 < MAXC) begin
            w = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (m_ptr + k) % NUM_REQ;
                if (w < 0 && req_valid[idx]) w = idx;
            end
            mk = req_mask[w*DW +: DW];
            vl = req_value[w*DW +: DW];
            nv = (m_reg & ~mk) | (vl & mk);
            e_cs[cyc+1]   = 1'b1;
            e_busy[cyc+1] = 1'b1;
            if (mk == '0) begin
                a = cyc + 2;
            end else begin
                a = cyc + 3;
                e_cs[cyc+2]   = 1'b1;
                e_wr[cyc+2]   = 1'b1;
                e_wd[cyc+2]   = nv;
                e_busy[cyc+2] = 1'b1;
            end
            e_busy[a]    = 1'b1;
            e_ack[a]     = NUM_REQ'(1) << w;
            e_rsp_set[a] = 1'b1;
            e_rsp[a]     = nv;
            m_reg   = nv;
            m_ptr   = (w + 1) % NUM_REQ;
            free_at = a + 1;
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (cyc < MAXC) begin
            if (!reset_n) begin
                held_rsp = '0;
                chk("rst_ack", 32'(req_ack), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_cs", 32'(av_chipselect), 32'd0);
                chk("rst_write_n", 32'(av_write_n), 32'd1);
                chk("rst_wdata", av_writedata, 32'd0);
                chk("rst_rsp", rsp_data, 32'd0);
            end else begin
                if (e_rsp_set[cyc]) held_rsp = e_rsp[cyc];
                chk("mdl_ack", 32'(req_ack), 32'(e_ack[cyc]));
                chk("mdl_busy", 32'(busy), 32'(e_busy[cyc]));
                chk("mdl_cs", 32'(av_chipselect), 32'(e_cs[cyc]));
                chk("mdl_write_n", 32'(av_write_n), 32'(!e_wr[cyc]));
                if (e_wr[cyc]) chk("mdl_wdata", av_writedata, e_wd[cyc]);
                chk("mdl_rsp", rsp_data, held_rsp);
            end
        end
    end

    // One request from requester i; returns ack/write cycle offsets from the grant cycle.
    task automatic do_op(input int i, input logic [31:0] m, input logic [31:0] v,
                         output int rel_ack, output int rel_wr,
                         output logic [31:0] wd, output logic [31:0] rsp);
        int g;
        @(negedge clk);
        req_mask[i*DW +: DW]  = m;
        req_value[i*DW +: DW] = v;
        req_valid[i] = 1'b1;
        g = cyc;
        rel_ack = -1; rel_wr = -1; wd = '0; rsp = '0;
        for (int k = 0; k < 20 && rel_ack < 0; k++) begin
            @(negedge clk);
            if (!av_write_n) begin
                rel_wr = cyc - g;
                wd     = av_writedata;
            end
            if (req_ack[i]) begin
                rel_ack = cyc - g;
                rsp     = rsp_data;
                req_valid[i] = 1'b0;
            end
        end
        req_valid[i] = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int ra, rw, nack, last, id;
        int cnt [NUM_REQ];
        int cs_cnt, ack_cnt;
        logic [31:0] wd, rsp;
        for (int c = 0; c < MAXC; c++) clear_cycle(c);

        repeat (3) @(negedge clk);
        chk("reset_cs", 32'(av_chipselect), 32'd0);
        chk("reset_rsp", rsp_data, 32'd0);
        #1 reset_n = 1'b1;

        // 1: masked write into a cleared register
        do_op(0, 32'h0000_00FF, 32'h0000_00A5, ra, rw, wd, rsp);
        chk("t1_write_cycle", 32'(rw), 32'd2);
        chk("t1_wdata", wd, 32'h0000_00A5);
        chk("t1_ack_cycle", 32'(ra), 32'd3);
        chk("t1_rsp", rsp, 32'h0000_00A5);

        // 2: all-ones mask preload, then a partial-byte merge
        do_op(0, 32'hFFFF_FFFF, 32'hFFFF_0000, ra, rw, wd, rsp);
        chk("t2_preload_rsp", rsp, 32'hFFFF_0000);
        do_op(1, 32'h0000_FF00, 32'h1234_5678, ra, rw, wd, rsp);
        chk("t2_wdata", wd, 32'hFFFF_5600);
        chk("t2_rsp", rsp, 32'hFFFF_5600);

        // 3: both requesters held continuously
        @(negedge clk);
        req_mask  = {32'h0000_FF00, 32'h0000_00FF};
        req_value = {32'h0000_0100, 32'h0000_0001};
        req_valid = 2'b11;
        nack = 0; last = 0; cnt[0] = 0; cnt[1] = 0;
        for (int k = 0; k < 60 && nack < 8; k++) begin
            @(negedge clk);
            if (|req_ack) begin
                id = req_ack[1] ? 1 : 0;
                chk("t3_grant_order", 32'(id), 32'(nack % 2));
                if (nack > 0) chk("t3_ack_gap", 32'(cyc - last), 32'd4);
                last = cyc;
                nack++;
                cnt[id]++;
                if (cnt[id] >= 4) req_valid[id] = 1'b0;
                else req_value[id*DW +: DW] = 32'(cnt[id] + 2) << (8 * id);
            end
        end
        req_valid = '0;
        chk("t3_total_acks", 32'(nack), 32'd8);

        // 4: read-only query
        do_op(0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, ra, rw, wd, rsp);
        do_op(0, 32'h0000_0000, 32'h1234_5678, ra, rw, wd, rsp);
        chk("t4_no_write", 32'(rw), 32'hFFFF_FFFF);
        chk("t4_ack_cycle", 32'(ra), 32'd2);
        chk("t4_rsp", rsp, 32'hDEAD_BEEF);

        // 5: reset in the middle of a write
        @(negedge clk);
        req_mask[DW +: DW]  = 32'hFF00_FF00;
        req_value[DW +: DW] = 32'h1234_5678;
        req_valid[1] = 1'b1;
        for (int k = 0; k < 10 && av_write_n; k++) @(negedge clk);
        chk("t5_in_write", 32'(av_write_n), 32'd0);
        #1 reset_n = 1'b0;
        req_valid = '0;
        #1;
        chk("t5_cs_drop", 32'(av_chipselect), 32'd0);
        chk("t5_ack_low", 32'(req_ack), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        req_mask  = {32'h0000_00F0, 32'h0000_000F};
        req_value = {32'h0000_00A0, 32'h0000_0005};
        req_valid = 2'b11;
        nack = 0;
        for (int k = 0; k < 20 && nack < 2; k++) begin
            @(negedge clk);
            if (|req_ack) begin
                id = req_ack[1] ? 1 : 0;
                if (nack == 0) begin
                    chk("t5_first_grant", 32'(id), 32'd0);
                    chk("t5_first_rsp", rsp_data, 32'h0000_0005);
                end else begin
                    chk("t5_second_rsp", rsp_data, 32'h0000_00A5);
                end
                req_valid[id] = 1'b0;
                nack++;
            end
        end
        req_valid = '0;
        chk("t5_acks", 32'(nack), 32'd2);

        // 6: valid withdrawn right after grant
        @(negedge clk);
        req_mask[0 +: DW]  = 32'h0000_FFFF;
        req_value[0 +: DW] = 32'h0000_1111;
        req_valid[0] = 1'b1;
        cs_cnt = 0; ack_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("t6_busy_after_grant", 32'(busy), 32'd1);
                req_valid[0] = 1'b0;
            end
            if (av_chipselect) cs_cnt++;
            if (req_ack[0]) begin
                ack_cnt++;
                chk("t6_rsp", rsp_data, 32'h0000_1111);
            end
        end
        chk("t6_ack_count", 32'(ack_cnt), 32'd1);
        chk("t6_cs_cycles", 32'(cs_cnt), 32'd2);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
